// File: rtl/spi_transaction_arbiter.sv
// Round-robin arbiter sharing one bidirectional SPI engine among NUM_REQ requesters,
// with inter-transaction chip-select gap and completion timeout.
module spi_transaction_arbiter #(
   parameter int unsigned NUM_REQ               = 4,
   parameter int unsigned DATA_WIDTH            = 32,
   parameter int unsigned TRANSACTION_LEN_WIDTH = 8,
   parameter int unsigned GAP_WIDTH             = 8,
   parameter int unsigned TIMEOUT_WIDTH         = 16
) (
   input  logic                                     fabric_clk,
   input  logic                                     reset,
   input  logic [NUM_REQ-1:0]                       req_valid,
   output logic [NUM_REQ-1:0]                       req_ready,
   input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_rw_mask,
   output logic [NUM_REQ-1:0]                       rsp_valid,
   output logic [DATA_WIDTH-1:0]                    rsp_read_data,
   output logic                                     rsp_error,
   input  logic [GAP_WIDTH-1:0]                     cfg_gap_cycles,
   input  logic [TIMEOUT_WIDTH-1:0]                 cfg_timeout_cycles,
   output logic                                     spi_start,
   output logic [TRANSACTION_LEN_WIDTH-1:0]         spi_length,
   output logic [DATA_WIDTH-1:0]                    spi_data,
   output logic [DATA_WIDTH-1:0]                    spi_rw_mask,
   input  logic                                     spi_done,
   input  logic [DATA_WIDTH-1:0]                    spi_read_data,
   output logic                                     spi_abort,
   output logic                                     busy
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_RESPOND,
      S_GAP
   } state_t;

   state_t                             state, state_nxt;
   logic [IDX_W-1:0]                   ptr, ptr_nxt;
   logic [IDX_W-1:0]                   idx_q, idx_nxt;
   logic                               illegal_q, illegal_nxt;
   logic [TIMEOUT_WIDTH-1:0]           tmo_cnt, tmo_nxt;
   logic [GAP_WIDTH-1:0]               gap_cnt, gap_nxt;
   logic [TRANSACTION_LEN_WIDTH-1:0]   len_nxt;
   logic [DATA_WIDTH-1:0]              data_nxt, mask_nxt;
   logic [DATA_WIDTH-1:0]              rdata_nxt;
   logic                               err_nxt;

   logic                               grant_found;
   logic [IDX_W-1:0]                   grant_idx;
   logic                               hi_found, lo_found;
   logic [IDX_W-1:0]                   hi_idx, lo_idx;
   logic [TRANSACTION_LEN_WIDTH-1:0]   sel_len;
   logic [DATA_WIDTH-1:0]              sel_data, sel_mask;
   logic                               len_legal;
   logic                               tmo_hit;

   // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = IDX_W'(i);
            if (IDX_W'(i) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
         end
      end
      grant_found = lo_found;
      grant_idx   = hi_found ? hi_idx : lo_idx;
   end

   // Winner's request fields
   always_comb begin
      sel_len  = '0;
      sel_data = '0;
      sel_mask = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_len  = req_length[i*TRANSACTION_LEN_WIDTH +: TRANSACTION_LEN_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_mask = req_rw_mask[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign len_legal = (sel_len != '0) && (32'(sel_len) <= DATA_WIDTH);
   assign tmo_hit   = (cfg_timeout_cycles != '0) &&
                      (tmo_cnt == cfg_timeout_cycles - TIMEOUT_WIDTH'(1));

   // Grant is only offered while idle and out of reset
   assign req_ready = (state == S_IDLE && !reset && grant_found) ?
                      (NUM_REQ'(1) << grant_idx) : '0;

   // Next-state and transaction bookkeeping
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      idx_nxt     = idx_q;
      illegal_nxt = illegal_q;
      tmo_nxt     = tmo_cnt;
      gap_nxt     = gap_cnt;
      len_nxt     = spi_length;
      data_nxt    = spi_data;
      mask_nxt    = spi_rw_mask;
      rdata_nxt   = '0;
      err_nxt     = 1'b0;
      spi_abort   = 1'b0;

      case (state)
         S_IDLE: begin
            if (grant_found) begin
               idx_nxt  = grant_idx;
               ptr_nxt  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
               len_nxt  = sel_len;
               data_nxt = sel_data;
               mask_nxt = sel_mask;
               if (len_legal) begin
                  illegal_nxt = 1'b0;
                  state_nxt   = S_ISSUE;
               end else begin
                  illegal_nxt = 1'b1;
                  err_nxt     = 1'b1;
                  state_nxt   = S_RESPOND;
               end
            end
         end
         S_ISSUE: begin
            tmo_nxt   = '0;
            state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            tmo_nxt = tmo_cnt + TIMEOUT_WIDTH'(1);
            if (spi_done) begin
               rdata_nxt = spi_read_data;
               state_nxt = S_RESPOND;
            end else if (tmo_hit) begin
               spi_abort = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = S_RESPOND;
            end
         end
         S_RESPOND: begin
            if (illegal_q || cfg_gap_cycles == '0) begin
               state_nxt = S_IDLE;
            end else begin
               gap_nxt   = cfg_gap_cycles - GAP_WIDTH'(1);
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               gap_nxt = gap_cnt - GAP_WIDTH'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge fabric_clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         ptr           <= '0;
         idx_q         <= '0;
         illegal_q     <= 1'b0;
         tmo_cnt       <= '0;
         gap_cnt       <= '0;
         spi_length    <= '0;
         spi_data      <= '0;
         spi_rw_mask   <= '0;
         spi_start     <= 1'b0;
         busy          <= 1'b0;
         rsp_valid     <= '0;
         rsp_read_data <= '0;
         rsp_error     <= 1'b0;
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         idx_q         <= idx_nxt;
         illegal_q     <= illegal_nxt;
         tmo_cnt       <= tmo_nxt;
         gap_cnt       <= gap_nxt;
         spi_length    <= len_nxt;
         spi_data      <= data_nxt;
         spi_rw_mask   <= mask_nxt;
         spi_start     <= (state_nxt == S_ISSUE);
         busy          <= (state_nxt != S_IDLE);
         rsp_valid     <= (state_nxt == S_RESPOND) ? (NUM_REQ'(1) << idx_nxt) : '0;
         rsp_read_data <= (state_nxt == S_RESPOND) ? rdata_nxt : '0;
         rsp_error     <= (state_nxt == S_RESPOND) && err_nxt;
      end
   end

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Bench for spi_transaction_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level round-robin/timing model.
module tb_spi_transaction_arbiter;

   logic           fabric_clk = 1'b0;
   logic           reset;
   logic [3:0]     req_valid;
   logic [3:0]     req_ready;
   logic [31:0]    req_length;
   logic [127:0]   req_data;
   logic [127:0]   req_rw_mask;
   logic [3:0]     rsp_valid;
   logic [31:0]    rsp_read_data;
   logic           rsp_error;
   logic [7:0]     cfg_gap_cycles;
   logic [15:0]    cfg_timeout_cycles;
   logic           spi_start;
   logic [7:0]     spi_length;
   logic [31:0]    spi_data;
   logic [31:0]    spi_rw_mask;
   logic           spi_done;
   logic [31:0]    spi_read_data;
   logic           spi_abort;
   logic           busy;

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;

   logic [7:0]  t_len  [4];
   logic [31:0] t_data [4];
   logic [31:0] t_mask [4];

   spi_transaction_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(32), .TRANSACTION_LEN_WIDTH(8),
      .GAP_WIDTH(8), .TIMEOUT_WIDTH(16)
   ) dut (
      .fabric_clk(fabric_clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_length(req_length), .req_data(req_data), .req_rw_mask(req_rw_mask),
      .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data), .rsp_error(rsp_error),
      .cfg_gap_cycles(cfg_gap_cycles), .cfg_timeout_cycles(cfg_timeout_cycles),
      .spi_start(spi_start), .spi_length(spi_length), .spi_data(spi_data),
      .spi_rw_mask(spi_rw_mask), .spi_done(spi_done), .spi_read_data(spi_read_data),
      .spi_abort(spi_abort), .busy(busy)
   );

   always #5 fabric_clk = ~fabric_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int o = 0; o < 4; o++)
         if (v[(p + o) % 4]) return (p + o) % 4;
      return 0;
   endfunction

   function automatic logic [3:0] onehot(input int g);
      logic [3:0] r;
      r = 4'b0001 << g;
      return r;
   endfunction

   task automatic drive_req(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         req_length[i*8 +: 8]   = t_len[i];
         req_data[i*32 +: 32]   = t_data[i];
         req_rw_mask[i*32 +: 32] = t_mask[i];
      end
      req_valid = v;
   endtask

   task automatic rand_fields();
      int r;
      for (int i = 0; i < 4; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      t_len[i] = 8'd0;
         else if (r == 1) t_len[i] = 8'($urandom_range(33, 255));
         else             t_len[i] = 8'($urandom_range(1, 32));
         t_data[i] = $urandom;
         t_mask[i] = $urandom;
      end
   endtask

   // One full transaction; entered and left just after a rising edge with the DUT idle.
   task automatic do_txn(input logic [3:0] vmask, input int lat, input logic [31:0] rd);
      int g, egap;
      logic [7:0]  elen;
      logic [31:0] edata, emask;
      bit legal, to;
      g     = pick(vmask, m_ptr);
      elen  = t_len[g];
      edata = t_data[g];
      emask = t_mask[g];
      legal = (elen != 8'd0) && (elen <= 8'd32);
      to    = legal && (cfg_timeout_cycles != 16'd0) && (lat > int'(cfg_timeout_cycles));
      drive_req(vmask);
      @(negedge fabric_clk);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_quiet", rsp_valid, 0);
      chk("grant", req_ready, onehot(g));
      m_ptr = (g + 1) % 4;
      @(posedge fabric_clk); #1;
      req_valid = '0;
      rand_fields();
      drive_req(4'b0000);
      @(negedge fabric_clk);
      if (legal) begin
         chk("spi_start", spi_start, 1);
         chk("spi_length", spi_length, elen);
         chk("spi_data", spi_data, edata);
         chk("spi_rw_mask", spi_rw_mask, emask);
         for (int w = 1; w <= lat; w++) begin
            @(posedge fabric_clk); #1;
            spi_done      = (w == lat);
            spi_read_data = (w == lat) ? rd : $urandom;
            @(negedge fabric_clk);
            chk("spi_abort", spi_abort, to && (w == int'(cfg_timeout_cycles)));
            chk("wait_rsp_quiet", rsp_valid, 0);
            chk("wait_start_low", spi_start, 0);
            if (to && (w == int'(cfg_timeout_cycles))) break;
         end
         @(posedge fabric_clk); #1;
         spi_done      = to;
         spi_read_data = $urandom;
         @(negedge fabric_clk);
         chk("rsp_valid", rsp_valid, onehot(g));
         chk("rsp_error", rsp_error, to);
         chk("rsp_read_data", rsp_read_data, to ? 32'd0 : rd);
      end else begin
         chk("illegal_no_start", spi_start, 0);
         chk("illegal_rsp_valid", rsp_valid, onehot(g));
         chk("illegal_rsp_error", rsp_error, 1);
         chk("illegal_rsp_data", rsp_read_data, 0);
      end
      chk("rsp_abort_low", spi_abort, 0);
      egap = legal ? int'(cfg_gap_cycles) : 0;
      for (int c = 0; c < egap; c++) begin
         @(posedge fabric_clk); #1;
         spi_done  = 1'b0;
         req_valid = 4'hF;
         @(negedge fabric_clk);
         chk("gap_no_ready", req_ready, 0);
         chk("gap_busy", busy, 1);
         chk("gap_rsp_quiet", rsp_valid, 0);
      end
      @(posedge fabric_clk); #1;
      spi_done  = 1'b0;
      req_valid = '0;
   endtask

   initial begin
      logic [3:0] v;
      reset              = 1'b1;
      req_valid          = '0;
      req_length         = '0;
      req_data           = '0;
      req_rw_mask        = '0;
      cfg_gap_cycles     = 8'd0;
      cfg_timeout_cycles = 16'd0;
      spi_done           = 1'b0;
      spi_read_data      = '0;
      for (int i = 0; i < 4; i++) begin
         t_len[i] = 8'd8; t_data[i] = 32'h0; t_mask[i] = 32'h0;
      end

      // Reset values
      repeat (2) @(negedge fabric_clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_read_data, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_spi_start", spi_start, 0);
      chk("rst_spi_length", spi_length, 0);
      chk("rst_spi_data", spi_data, 0);
      chk("rst_spi_mask", spi_rw_mask, 0);
      chk("rst_spi_abort", spi_abort, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      @(posedge fabric_clk); #1;

      // Round-robin with all requesters held valid: 0,1,2,3,0
      cfg_gap_cycles = 8'd1;
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < 4; i++) begin
            t_len[i] = 8'(4 + i); t_data[i] = $urandom; t_mask[i] = $urandom;
         end
         chk("rr_model_order", 32'(pick(4'hF, m_ptr)), 32'(n % 4));
         do_txn(4'hF, 3, $urandom);
      end

      // Single request on requester 2
      cfg_gap_cycles = 8'd0;
      t_len[2] = 8'd16; t_data[2] = 32'hA5A5_0000; t_mask[2] = 32'hFFFF_0000;
      do_txn(4'b0100, 10, 32'h0000_1234);

      // Gap enforcement with back-to-back requests, then gap 0
      cfg_gap_cycles = 8'd5;
      t_len[1] = 8'd32; t_len[3] = 8'd1;
      do_txn(4'b1010, 2, 32'hCAFE_0001);
      do_txn(4'b1010, 2, 32'hCAFE_0002);
      cfg_gap_cycles = 8'd0;
      t_len[0] = 8'd7;
      do_txn(4'b0001, 1, 32'hCAFE_0003);
      do_txn(4'b0001, 1, 32'hCAFE_0004);

      // Timeout at 20 with a late done ignored
      cfg_timeout_cycles = 16'd20;
      cfg_gap_cycles     = 8'd2;
      t_len[1] = 8'd12;
      do_txn(4'b0010, 30, 32'hDEAD_BEEF);

      // Illegal lengths 0 and 33, then done coinciding with timeout
      t_len[2] = 8'd0;
      do_txn(4'b0100, 3, 32'h1);
      t_len[3] = 8'd33;
      do_txn(4'b1000, 3, 32'h2);
      t_len[0] = 8'd20;
      do_txn(4'b0001, 20, 32'h5555_AAAA);

      // Reset during WAIT_DONE
      cfg_timeout_cycles = 16'd0;
      t_len[2] = 8'd8;
      drive_req(4'b0100);
      @(posedge fabric_clk); #1;
      req_valid = '0;
      repeat (2) begin @(posedge fabric_clk); #1; end
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_abort", spi_abort, 0);
      chk("midrst_rsp", rsp_valid, 0);
      chk("midrst_length", spi_length, 0);
      repeat (2) begin
         @(negedge fabric_clk);
         chk("midrst_hold_rsp", rsp_valid, 0);
         chk("midrst_hold_abort", spi_abort, 0);
      end
      reset = 1'b0;
      m_ptr = 0;
      @(posedge fabric_clk); #1;
      chk("postrst_rsp", rsp_valid, 0);
      t_len[1] = 8'd9; t_len[3] = 8'd9;
      do_txn(4'b1010, 4, 32'h0BAD_F00D);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         cfg_gap_cycles = 8'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       cfg_timeout_cycles = 16'd0;
            1:       cfg_timeout_cycles = 16'd6;
            default: cfg_timeout_cycles = 16'd10;
         endcase
         rand_fields();
         v = 4'($urandom_range(1, 15));
         do_txn(v, $urandom_range(1, 12), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
